// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 write sequencer. Runs the power-on init commands on its
// own, then accepts one command/character byte per valid/ready handshake and
// produces the RS/data setup, EN pulse, hold and execution wait for it.
module lcd_ctrl #(
    parameter int T_POWERUP = 750000,
    parameter int T_SETUP   = 2,
    parameter int T_PULSE   = 12,
    parameter int T_HOLD    = 2,
    parameter int T_EXEC    = 2000,
    parameter int T_CLEAR   = 82000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_init_done,
    output logic       o_lcd_on,
    output logic       o_lcd_en,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_POWERUP, T_SETUP), max2(T_PULSE, T_HOLD)),
                                max2(T_EXEC, T_CLEAR));
    localparam int CNT_W = $clog2(T_MAX + 1);

    // Each state lasts N cycles, so the counter is loaded with N-1 on entry.
    localparam logic [CNT_W-1:0] L_POWERUP = CNT_W'(T_POWERUP - 1);
    localparam logic [CNT_W-1:0] L_SETUP   = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] L_PULSE   = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] L_HOLD    = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] L_EXEC    = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] L_CLEAR   = CNT_W'(T_CLEAR - 1);

    typedef enum logic [2:0] {
        S_POWERUP,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    // Function set 8-bit/2-line, display on, clear, entry mode increment.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Clear display and return home need the long execution wait.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] d);
        return !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    endfunction

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0]       init_idx, idx_next;
    logic             done_next;
    logic             rs_next;
    logic [7:0]       data_next;

    // Write-only interface: R/W is tied low.
    assign o_lcd_rw = 1'b0;

    // Next-state, counter reload and bus-value selection.
    always_comb begin
        state_next = state;
        cnt_next   = cnt - CNT_W'(1);
        idx_next   = init_idx;
        done_next  = o_init_done;
        rs_next    = o_lcd_rs;
        data_next  = o_lcd_data;
        case (state)
            S_POWERUP: begin
                if (cnt == '0) begin
                    state_next = S_SETUP;
                    cnt_next   = L_SETUP;
                    rs_next    = 1'b0;
                    data_next  = init_cmd(init_idx);
                end
            end
            S_IDLE: begin
                cnt_next = cnt;
                if (i_valid && o_ready) begin
                    state_next = S_SETUP;
                    cnt_next   = L_SETUP;
                    rs_next    = i_rs;
                    data_next  = i_data;
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_next = S_PULSE;
                    cnt_next   = L_PULSE;
                end
            end
            S_PULSE: begin
                if (cnt == '0) begin
                    state_next = S_HOLD;
                    cnt_next   = L_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    state_next = S_WAIT;
                    cnt_next   = is_slow_cmd(o_lcd_rs, o_lcd_data) ? L_CLEAR : L_EXEC;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    if (o_init_done) begin
                        state_next = S_IDLE;
                    end else if (init_idx == 2'd3) begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = S_SETUP;
                        cnt_next   = L_SETUP;
                        idx_next   = init_idx + 2'd1;
                        rs_next    = 1'b0;
                        data_next  = init_cmd(init_idx + 2'd1);
                    end
                end
            end
            default: begin
                state_next = S_POWERUP;
                cnt_next   = L_POWERUP;
            end
        endcase
    end

    // State/counter register; every output is registered from the next state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_POWERUP;
            cnt         <= L_POWERUP;
            init_idx    <= 2'd0;
            o_init_done <= 1'b0;
            o_ready     <= 1'b0;
            o_lcd_on    <= 1'b0;
            o_lcd_en    <= 1'b0;
            o_lcd_rs    <= 1'b0;
            o_lcd_data  <= 8'h00;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            init_idx    <= idx_next;
            o_init_done <= done_next;
            o_ready     <= (state_next == S_IDLE);
            o_lcd_on    <= 1'b1;
            o_lcd_en    <= (state_next == S_PULSE);
            o_lcd_rs    <= rs_next;
            o_lcd_data  <= data_next;
        end
    end

endmodule
